// File: rtl/decoder_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_if
// Description : Request / one-hot beat bundle for decoder_scan.
// Revision    : 1.0
// ============================================================================
interface decoder_scan_if #(
    parameter int N = 3
);
    localparam int OUT_W = 2**N;

    logic [N-1:0]     d;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic [OUT_W-1:0] y;
    logic             y_valid;
    logic             out_ready;
    logic             y_last;

    modport master (
        output d, mode, in_valid, abort, out_ready,
        input  in_ready, y, y_valid, y_last
    );

    modport slave (
        input  d, mode, in_valid, abort, out_ready,
        output in_ready, y, y_valid, y_last
    );
endinterface
`default_nettype wire

// File: rtl/decoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan
// Description : Registered one-hot decoder with single-beat and scan modes.
// Revision    : 1.0
// ============================================================================
module decoder_scan #(
    parameter int N = 3
) (
    input  wire            clk,
    input  wire            rst_n,
    decoder_scan_if.slave  bus
);
    localparam int OUT_W = 2**N;
    localparam logic [N-1:0] POS_MAX = N'(OUT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_SCAN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pos_q, pos_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             y_last_q, y_last_d;
    logic [N-1:0]     w_pos_inc;

    assign w_pos_inc = pos_q + N'(1);

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_last_d  = y_last_q;
        if (bus.abort) begin
            state_d   = S_IDLE;
            y_d       = '0;
            y_valid_d = 1'b0;
            y_last_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        state_d   = bus.mode ? S_SCAN : S_HOLD;
                        pos_d     = bus.d;
                        y_d       = OUT_W'(1) << bus.d;
                        y_valid_d = 1'b1;
                        y_last_d  = bus.mode ? (bus.d == POS_MAX) : 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        state_d   = S_IDLE;
                        y_d       = '0;
                        y_valid_d = 1'b0;
                        y_last_d  = 1'b0;
                    end
                end
                S_SCAN: begin
                    // The last position ends the scan instead of wrapping.
                    if (bus.out_ready) begin
                        if (pos_q == POS_MAX) begin
                            state_d   = S_IDLE;
                            y_d       = '0;
                            y_valid_d = 1'b0;
                            y_last_d  = 1'b0;
                        end else begin
                            pos_d    = w_pos_inc;
                            y_d      = y_q << 1;
                            y_last_d = (w_pos_inc == POS_MAX);
                        end
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    y_d       = '0;
                    y_valid_d = 1'b0;
                    y_last_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pos_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_last_q  <= y_last_d;
        end
    end

    assign bus.in_ready = (state_q == S_IDLE);
    assign bus.y        = y_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.y_last   = y_last_q;
endmodule
`default_nettype wire

// File: tb/tb_decoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_scan
// Description : Directed self-checking bench for decoder_scan (N = 3, 1, 6).
// Revision    : 1.0
// ============================================================================
module tb_decoder_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   inv_en = 1'b0;

    always #5 clk = ~clk;

    decoder_scan_if #(.N(3)) if3 ();
    decoder_scan_if #(.N(1)) if1 ();
    decoder_scan_if #(.N(6)) if6 ();

    decoder_scan #(.N(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    decoder_scan #(.N(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    decoder_scan #(.N(6)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(if6));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [7:0] ey, input logic ev,
                        input logic el, input logic er);
        chk({tag, ".y"},        if3.y, ey);
        chk({tag, ".y_valid"},  if3.y_valid, ev);
        chk({tag, ".y_last"},   if3.y_last, el);
        chk({tag, ".in_ready"}, if3.in_ready, er);
    endtask

    task automatic req3(input logic [2:0] dd, input logic md);
        if3.d = dd;
        if3.mode = md;
        if3.in_valid = 1'b1;
        step();
        if3.in_valid = 1'b0;
    endtask

    // One-hot-when-valid / zero-when-idle invariant on every DUT, every cycle.
    always @(negedge clk) begin
        if (inv_en) begin
            chk("inv3", if3.y_valid ? $onehot(if3.y) : (if3.y == '0), 1'b1);
            chk("inv1", if1.y_valid ? $onehot(if1.y) : (if1.y == '0), 1'b1);
            chk("inv6", if6.y_valid ? $onehot(if6.y) : (if6.y == '0), 1'b1);
        end
    end

    initial begin
        logic [63:0] ey;
        {if3.d, if3.mode, if3.in_valid, if3.abort, if3.out_ready} = '0;
        {if1.d, if1.mode, if1.in_valid, if1.abort, if1.out_ready} = '0;
        {if6.d, if6.mode, if6.in_valid, if6.abort, if6.out_ready} = '0;

        // Reset
        step();
        step();
        rst_n = 1'b1;
        inv_en = 1'b1;
        chk3("reset", 8'h00, 1'b0, 1'b0, 1'b1);

        // Single decode d=5
        if3.out_ready = 1'b1;
        req3(3'd5, 1'b0);
        chk3("hold5", 8'h20, 1'b1, 1'b1, 1'b0);
        step();
        chk3("hold5_done", 8'h00, 1'b0, 1'b0, 1'b1);

        // Scan from 5
        req3(3'd5, 1'b1);
        chk3("scan5_b0", 8'h20, 1'b1, 1'b0, 1'b0);
        step();
        chk3("scan5_b1", 8'h40, 1'b1, 1'b0, 1'b0);
        step();
        chk3("scan5_b2", 8'h80, 1'b1, 1'b1, 1'b0);
        step();
        chk3("scan5_done", 8'h00, 1'b0, 1'b0, 1'b1);

        // Scan from 2 with a stall on 0x08
        req3(3'd2, 1'b1);
        chk3("scan2_b0", 8'h04, 1'b1, 1'b0, 1'b0);
        step();
        chk3("scan2_b1", 8'h08, 1'b1, 1'b0, 1'b0);
        if3.out_ready = 1'b0;
        step();
        chk3("scan2_stall", 8'h08, 1'b1, 1'b0, 1'b0);
        if3.out_ready = 1'b1;
        step();
        chk3("scan2_b2", 8'h10, 1'b1, 1'b0, 1'b0);
        step();
        chk3("scan2_b3", 8'h20, 1'b1, 1'b0, 1'b0);
        step();
        chk3("scan2_b4", 8'h40, 1'b1, 1'b0, 1'b0);
        step();
        chk3("scan2_b5", 8'h80, 1'b1, 1'b1, 1'b0);
        step();
        chk3("scan2_done", 8'h00, 1'b0, 1'b0, 1'b1);

        // Scan from 0, abort on the third beat, then a fresh request
        req3(3'd0, 1'b1);
        chk3("scan0_b0", 8'h01, 1'b1, 1'b0, 1'b0);
        step();
        chk3("scan0_b1", 8'h02, 1'b1, 1'b0, 1'b0);
        step();
        chk3("scan0_b2", 8'h04, 1'b1, 1'b0, 1'b0);
        if3.abort = 1'b1;
        step();
        if3.abort = 1'b0;
        chk3("abort", 8'h00, 1'b0, 1'b0, 1'b1);
        req3(3'd3, 1'b0);
        chk3("after_abort", 8'h08, 1'b1, 1'b1, 1'b0);
        step();
        chk3("after_abort_done", 8'h00, 1'b0, 1'b0, 1'b1);

        // in_valid with abort in IDLE is not accepted
        if3.abort = 1'b1;
        req3(3'd1, 1'b0);
        if3.abort = 1'b0;
        chk3("valid_abort", 8'h00, 1'b0, 1'b0, 1'b1);

        // HOLD stall, in_valid ignored while busy
        if3.out_ready = 1'b0;
        req3(3'd6, 1'b0);
        chk3("hold6", 8'h40, 1'b1, 1'b1, 1'b0);
        step();
        chk3("hold6_stall", 8'h40, 1'b1, 1'b1, 1'b0);
        req3(3'd1, 1'b0);
        chk3("hold6_ignore", 8'h40, 1'b1, 1'b1, 1'b0);
        if3.out_ready = 1'b1;
        step();
        chk3("hold6_done", 8'h00, 1'b0, 1'b0, 1'b1);

        // Scan from the top position: one beat, y_last set
        req3(3'd7, 1'b1);
        chk3("scan7", 8'h80, 1'b1, 1'b1, 1'b0);
        step();
        chk3("scan7_done", 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset mid-scan, dominating out_ready and abort-free continuation
        req3(3'd0, 1'b1);
        step();
        chk3("scanr_b1", 8'h02, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk3("mid_reset", 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        chk3("post_reset", 8'h00, 1'b0, 1'b0, 1'b1);

        // Exhaustive single decode, N=1 and N=6
        if1.out_ready = 1'b1;
        if6.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if6.d = 6'(i);
            if6.in_valid = 1'b1;
            if (i < 2) begin
                if1.d = 1'(i);
                if1.in_valid = 1'b1;
            end
            step();
            if6.in_valid = 1'b0;
            if1.in_valid = 1'b0;
            ey = 64'd1 << i;
            chk("n6.y", if6.y, ey);
            chk("n6.y_last", if6.y_last, 1'b1);
            if (i < 2) begin
                chk("n1.y", if1.y, ey);
                chk("n1.y_last", if1.y_last, 1'b1);
            end
            step();
            chk("n6.idle", if6.y, 64'd0);
            chk("n6.in_ready", if6.in_ready, 1'b1);
        end
        chk("n1.idle", if1.y, 64'd0);

        // N=1 scan from 0: two beats
        if1.d = 1'b0;
        if1.mode = 1'b1;
        if1.in_valid = 1'b1;
        step();
        if1.in_valid = 1'b0;
        chk("n1.scan_b0", {if1.y, if1.y_last}, {2'b01, 1'b0});
        step();
        chk("n1.scan_b1", {if1.y, if1.y_last}, {2'b10, 1'b1});
        step();
        chk("n1.scan_done", {if1.y, if1.y_valid}, 3'b000);

        inv_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
